// File: rtl/dat_write_seq.sv
// Block-write sequencer for an SD data path: paces single/multi/infinite block writes
// through a data-write engine and reports completion, sticky errors and CMD12 requests.
module dat_write_seq #(
  parameter int unsigned BlockCountWidth = 16,
  parameter int unsigned GapCycles       = 2
) (
  input  logic                       sd_clk_i,
  input  logic                       rst_i,
  input  logic                       xfer_start_i,
  input  logic [BlockCountWidth-1:0] block_count_i,
  input  logic                       infinite_i,
  input  logic                       auto_cmd12_en_i,
  input  logic                       stop_req_i,
  input  logic                       buf_ready_i,
  output logic                       wr_start_o,
  input  logic                       wr_done_i,
  input  logic                       wr_crc_err_i,
  input  logic                       wr_end_bit_err_i,
  output logic                       busy_o,
  output logic [BlockCountWidth-1:0] blocks_done_o,
  output logic                       xfer_done_o,
  output logic                       crc_err_o,
  output logic                       end_bit_err_o,
  output logic                       auto_cmd12_req_o
);

  localparam int unsigned GapW = (GapCycles > 1) ? $clog2(GapCycles) : 1;
  localparam logic [GapW-1:0] GapLast = GapW'(GapCycles - 1);

  localparam logic [2:0] StIdle    = 3'd0;
  localparam logic [2:0] StWaitBuf = 3'd1;
  localparam logic [2:0] StStart   = 3'd2;
  localparam logic [2:0] StActive  = 3'd3;
  localparam logic [2:0] StGap     = 3'd4;
  localparam logic [2:0] StDone    = 3'd5;

  logic [2:0]                 state_q, state_d;
  logic [BlockCountWidth-1:0] remaining_q, remaining_d;
  logic [BlockCountWidth-1:0] blocks_q, blocks_d;
  logic [GapW-1:0]            gap_cnt_q, gap_cnt_d;
  logic                       crc_q, crc_d;
  logic                       end_q, end_d;
  logic                       stop_pend_q, stop_pend_d;
  logic                       inf_q, inf_d;
  logic                       cmd12_en_q, cmd12_en_d;
  logic                       multi_q, multi_d;
  logic                       stop_now;
  logic                       blk_err;

  // A stop arriving in the same cycle as the decision counts as already pending.
  assign stop_now = stop_pend_q | stop_req_i;
  assign blk_err  = wr_crc_err_i | wr_end_bit_err_i;

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    blocks_d    = blocks_q;
    gap_cnt_d   = gap_cnt_q;
    crc_d       = crc_q;
    end_d       = end_q;
    stop_pend_d = stop_pend_q;
    inf_d       = inf_q;
    cmd12_en_d  = cmd12_en_q;
    multi_d     = multi_q;

    if (state_q != StIdle && stop_req_i) begin
      stop_pend_d = 1'b1;
    end

    case (state_q)
      StIdle: begin
        if (xfer_start_i) begin
          inf_d       = infinite_i;
          cmd12_en_d  = auto_cmd12_en_i;
          multi_d     = (block_count_i > BlockCountWidth'(1));
          remaining_d = block_count_i;
          blocks_d    = '0;
          crc_d       = 1'b0;
          end_d       = 1'b0;
          stop_pend_d = 1'b0;
          if (block_count_i == '0 && !infinite_i) begin
            state_d = StDone;
          end else begin
            state_d = StWaitBuf;
          end
        end
      end
      StWaitBuf: begin
        if (stop_now) begin
          state_d = StDone;
        end else if (buf_ready_i) begin
          state_d = StStart;
        end
      end
      StStart: begin
        state_d = StActive;
      end
      StActive: begin
        if (wr_done_i) begin
          blocks_d = blocks_q + BlockCountWidth'(1);
          if (!inf_q) begin
            remaining_d = remaining_q - BlockCountWidth'(1);
          end
          crc_d = crc_q | wr_crc_err_i;
          end_d = end_q | wr_end_bit_err_i;
          if (blk_err) begin
            state_d = StDone;
          end else if (!inf_q && remaining_q == BlockCountWidth'(1)) begin
            state_d = StDone;
          end else if (stop_now) begin
            state_d = StDone;
          end else begin
            gap_cnt_d = '0;
            state_d   = StGap;
          end
        end
      end
      StGap: begin
        if (gap_cnt_q == GapLast) begin
          state_d = StWaitBuf;
        end else begin
          gap_cnt_d = gap_cnt_q + GapW'(1);
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge sd_clk_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      remaining_q <= '0;
      blocks_q    <= '0;
      gap_cnt_q   <= '0;
      crc_q       <= 1'b0;
      end_q       <= 1'b0;
      stop_pend_q <= 1'b0;
      inf_q       <= 1'b0;
      cmd12_en_q  <= 1'b0;
      multi_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      blocks_q    <= blocks_d;
      gap_cnt_q   <= gap_cnt_d;
      crc_q       <= crc_d;
      end_q       <= end_d;
      stop_pend_q <= stop_pend_d;
      inf_q       <= inf_d;
      cmd12_en_q  <= cmd12_en_d;
      multi_q     <= multi_d;
    end
  end

  // Outputs are gated by rst_i so they read as reset during the whole reset window.
  always_comb begin
    busy_o           = !rst_i && (state_q != StIdle);
    wr_start_o       = !rst_i && (state_q == StStart);
    xfer_done_o      = !rst_i && (state_q == StDone);
    auto_cmd12_req_o = !rst_i && (state_q == StDone) && cmd12_en_q && (multi_q || inf_q);
    blocks_done_o    = rst_i ? '0 : blocks_q;
    crc_err_o        = !rst_i && crc_q;
    end_bit_err_o    = !rst_i && end_q;
  end

endmodule

// File: tb/tb_dat_write_seq.sv
// Bench for dat_write_seq: table vectors, reset/ignore sequences and randomized transfers
// checked against a block-count model, with a behavioural write engine.
module tb_dat_write_seq;

  localparam int unsigned Bcw = 16;
  localparam int unsigned Gap = 2;

  logic           sd_clk;
  logic           rst;
  logic           xfer_start;
  logic [Bcw-1:0] block_count;
  logic           infinite;
  logic           cmd12_en;
  logic           stop_req;
  logic           buf_ready;
  logic           wr_start;
  logic           wr_done;
  logic           wr_crc_err;
  logic           wr_end_err;
  logic           busy;
  logic [Bcw-1:0] blocks_done;
  logic           xfer_done;
  logic           crc_err;
  logic           end_bit_err;
  logic           cmd12_req;

  dat_write_seq #(
    .BlockCountWidth(Bcw),
    .GapCycles      (Gap)
  ) dut (
    .sd_clk_i        (sd_clk),
    .rst_i           (rst),
    .xfer_start_i    (xfer_start),
    .block_count_i   (block_count),
    .infinite_i      (infinite),
    .auto_cmd12_en_i (cmd12_en),
    .stop_req_i      (stop_req),
    .buf_ready_i     (buf_ready),
    .wr_start_o      (wr_start),
    .wr_done_i       (wr_done),
    .wr_crc_err_i    (wr_crc_err),
    .wr_end_bit_err_i(wr_end_err),
    .busy_o          (busy),
    .blocks_done_o   (blocks_done),
    .xfer_done_o     (xfer_done),
    .crc_err_o       (crc_err),
    .end_bit_err_o   (end_bit_err),
    .auto_cmd12_req_o(cmd12_req)
  );

  initial sd_clk = 1'b0;
  always #5 sd_clk = ~sd_clk;

  typedef struct {
    int count;
    bit inf;
    bit cmd12;
    int err_blk;    // 1-based block that reports an error, 0 = none
    int err_kind;   // bit0 crc, bit1 end bit
    int stop_blk;   // block during which stop_req is pulsed, 0 = none
    int lat;        // engine cycles from start to done
    int buf_delay;  // cycles before buf_ready rises
    int exp_blocks;
    bit exp_crc;
    bit exp_end;
    bit exp_cmd12;
  } vec_t;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: a transfer completes the fewest of {count, error block, stop block}.
  function automatic void model(inout vec_t v);
    int lim;
    if (!v.inf && v.count == 0) begin
      lim = 0;
    end else begin
      lim = v.inf ? 1000000 : v.count;
      if (v.err_blk > 0 && v.err_blk < lim) lim = v.err_blk;
      if (v.stop_blk > 0 && v.stop_blk < lim) lim = v.stop_blk;
    end
    v.exp_blocks = lim;
    v.exp_crc    = (v.err_blk > 0) && (v.err_blk <= lim) && v.err_kind[0];
    v.exp_end    = (v.err_blk > 0) && (v.err_blk <= lim) && v.err_kind[1];
    v.exp_cmd12  = v.cmd12 && (v.count > 1 || v.inf);
  endfunction

  task automatic run_xfer(input vec_t v, input string name);
    int cyc, starts, dones, last_done, first_start, eng_cnt, gap_bad, overlap, stray, post;
    int exp_first;
    bit eng_busy, stop_sent;
    logic [Bcw-1:0] blk_at;
    logic crc_at, end_at, c12_at;
    cyc = 0; starts = 0; dones = 0; last_done = 0; first_start = -1; eng_cnt = 0;
    gap_bad = 0; overlap = 0; stray = 0; post = -1; eng_busy = 0; stop_sent = 0;
    blk_at = '0; crc_at = 0; end_at = 0; c12_at = 0;
    xfer_start  = 1'b1;
    block_count = Bcw'(v.count);
    infinite    = v.inf;
    cmd12_en    = v.cmd12;
    buf_ready   = (v.buf_delay == 0);
    while (cyc < 3000 && !(post >= 0 && cyc >= post + 8)) begin
      @(negedge sd_clk);
      cyc++;
      xfer_start = 1'b0; stop_req = 1'b0;
      wr_done = 1'b0; wr_crc_err = 1'b0; wr_end_err = 1'b0;
      if (cyc >= v.buf_delay) buf_ready = 1'b1;
      if (xfer_done) begin
        dones++;
        if (post < 0) begin
          post = cyc; blk_at = blocks_done; crc_at = crc_err; end_at = end_bit_err;
          c12_at = cmd12_req;
        end
      end
      if (cmd12_req && !xfer_done) stray++;
      if (wr_start) begin
        starts++;
        if (eng_busy) overlap++;
        if (starts == 1) first_start = cyc;
        else if (cyc - last_done != int'(Gap) + 2) gap_bad++;
        eng_busy = 1; eng_cnt = v.lat;
      end else if (eng_busy) begin
        eng_cnt--;
        if (eng_cnt == 0) begin
          wr_done = 1'b1;
          if (starts == v.err_blk) begin
            wr_crc_err = v.err_kind[0];
            wr_end_err = v.err_kind[1];
          end
          eng_busy = 0; last_done = cyc;
        end else if (starts == v.stop_blk && !stop_sent) begin
          stop_req = 1'b1; stop_sent = 1;
        end
      end
    end
    check({name, " starts"}, starts, v.exp_blocks);
    check({name, " xfer_done pulses"}, dones, 1);
    check({name, " blocks_done"}, blk_at, v.exp_blocks);
    check({name, " crc_err"}, crc_at, v.exp_crc);
    check({name, " end_bit_err"}, end_at, v.exp_end);
    check({name, " auto_cmd12"}, c12_at, v.exp_cmd12);
    check({name, " busy after"}, busy, 0);
    check({name, " gap timing"}, gap_bad, 0);
    check({name, " start overlap"}, overlap, 0);
    check({name, " stray cmd12"}, stray, 0);
    if (v.exp_blocks > 0) begin
      exp_first = ((v.buf_delay < 1) ? 1 : v.buf_delay) + 1;
      check({name, " first start"}, first_start, exp_first);
    end
  endtask

  vec_t tbl[10];
  vec_t rv;
  logic [Bcw-1:0] hold_blk;
  logic hold_crc;
  int seen;

  initial begin
    //        cnt inf c12 eblk kind stop lat  bufd  exp: blk crc end c12
    tbl[0] = '{3,   0,  1,  0,   0,   0,  100, 0,        3,  0,  0,  1};
    tbl[1] = '{1,   0,  1,  0,   0,   0,  10,  0,        1,  0,  0,  0};
    tbl[2] = '{4,   0,  1,  2,   1,   0,  20,  0,        2,  1,  0,  1};
    tbl[3] = '{0,   1,  0,  0,   0,   5,  30,  0,        5,  0,  0,  0};
    tbl[4] = '{2,   0,  0,  0,   0,   0,  10,  50,       2,  0,  0,  0};
    tbl[5] = '{0,   0,  1,  0,   0,   0,  10,  0,        0,  0,  0,  0};
    tbl[6] = '{3,   0,  0,  3,   2,   0,  5,   0,        3,  0,  1,  0};
    tbl[7] = '{5,   0,  1,  0,   0,   2,  8,   0,        2,  0,  0,  1};
    tbl[8] = '{0,   1,  1,  3,   3,   0,  4,   3,        3,  1,  1,  1};
    tbl[9] = '{2,   0,  1,  0,   0,   0,  3,   0,        2,  0,  0,  1};

    rst = 1'b1; xfer_start = 0; block_count = '0; infinite = 0; cmd12_en = 0;
    stop_req = 0; buf_ready = 0; wr_done = 0; wr_crc_err = 0; wr_end_err = 0;
    repeat (3) @(negedge sd_clk);
    check("reset busy", busy, 0);
    check("reset blocks_done", blocks_done, 0);
    check("reset xfer_done", xfer_done, 0);
    check("reset errs", {crc_err, end_bit_err}, 0);
    rst = 1'b0;
    @(negedge sd_clk);
    check("post-reset busy", busy, 0);

    for (int i = 0; i < 10; i++) begin
      run_xfer(tbl[i], $sformatf("vec%0d", i));
    end

    // Engine completion while idle must not touch counters or sticky flags.
    hold_blk = blocks_done; hold_crc = crc_err;
    wr_done = 1'b1; wr_crc_err = 1'b1;
    @(negedge sd_clk);
    wr_done = 1'b0; wr_crc_err = 1'b0;
    @(negedge sd_clk);
    check("idle done blocks", blocks_done, hold_blk);
    check("idle done crc", crc_err, hold_crc);
    check("idle done busy", busy, 0);

    // Reset in the middle of block 2, then a clean transfer.
    xfer_start = 1'b1; block_count = Bcw'(5); infinite = 0; cmd12_en = 1; buf_ready = 1;
    seen = 0;
    for (int c = 0; c < 20 && seen == 0; c++) begin
      @(negedge sd_clk);
      xfer_start = 1'b0;
      if (wr_start) seen = 1;
    end
    check("rst seq first start", seen, 1);
    repeat (3) @(negedge sd_clk);
    wr_done = 1'b1;
    @(negedge sd_clk);
    wr_done = 1'b0;
    seen = 0;
    for (int c = 0; c < 20 && seen == 0; c++) begin
      @(negedge sd_clk);
      if (wr_start) seen = 1;
    end
    check("rst seq second start", seen, 1);
    @(negedge sd_clk);
    @(negedge sd_clk);
    check("rst seq blocks before", blocks_done, 1);
    check("rst seq busy before", busy, 1);
    rst = 1'b1;
    #1;
    check("in-reset busy", busy, 0);
    check("in-reset blocks", blocks_done, 0);
    @(negedge sd_clk);
    check("in-reset pulses", {wr_start, xfer_done, cmd12_req}, 0);
    @(negedge sd_clk);
    rst = 1'b0;
    seen = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge sd_clk);
      if (xfer_done || busy || wr_start) seen++;
    end
    check("no stale activity", seen, 0);
    run_xfer(tbl[9], "after-reset");

    for (int i = 0; i < 24; i++) begin
      rv.count     = int'($urandom_range(0, 6));
      rv.inf       = ($urandom_range(0, 3) == 0);
      rv.cmd12     = $urandom_range(0, 1) == 1;
      rv.err_blk   = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 6)) : 0;
      rv.err_kind  = int'($urandom_range(1, 3));
      rv.stop_blk  = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 6)) : 0;
      if (rv.inf && rv.err_blk == 0 && rv.stop_blk == 0) rv.stop_blk = int'($urandom_range(1, 5));
      rv.lat       = int'($urandom_range(3, 12));
      rv.buf_delay = int'($urandom_range(0, 6));
      model(rv);
      run_xfer(rv, $sformatf("rnd%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
